prog_divider: RTL and testbench



---
 rtl/prog_divider_pkg.sv | 15 +
 rtl/prog_divider_ch.sv | 80 ++++++++
 rtl/prog_divider.sv | 58 +++++
 tb/tb_prog_divider.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/prog_divider_pkg.sv
// Shared types and defaults for the multi-channel programmable clock divider.
package prog_divider_pkg;

  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_PULSE  = 1'b1
  } mode_e;

  localparam int unsigned CH_IDX_W     = 3;
  localparam int unsigned DEF_WIDTH    = 26;
  localparam int unsigned DEF_CHANNELS = 2;
  localparam int unsigned DEF_TAP_BITS = 5;
  localparam logic [25:0] DEF_RELOAD   = 26'h3938700;

endpackage

// File: rtl/prog_divider_ch.sv
// One divider channel: reloadable down-counter with toggle or pulse output.
module prog_divider_ch
  import prog_divider_pkg::*;
#(
  parameter int unsigned       WIDTH          = DEF_WIDTH,
  parameter logic [WIDTH-1:0]  DEFAULT_RELOAD = WIDTH'(DEF_RELOAD)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             wr,
  input  logic             restart,
  input  logic [WIDTH-1:0] wr_reload,
  input  logic             wr_mode,
  output logic [WIDTH-1:0] count,
  output logic             out_pin,
  output logic             tick
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  mode_e            mode_q, mode_d;
  // Mode currently shaping out_pin; lags mode_q until the next wrap so a
  // mode change without restart leaves out_pin alone until then.
  mode_e            out_mode_q, out_mode_d;
  logic             out_q, out_d;
  logic             tick_q, tick_d;

  // Next-state: restart wins, then wrap/decrement when running, else hold.
  always_comb begin
    count_d    = count_q;
    reload_d   = wr ? wr_reload : reload_q;
    mode_d     = wr ? mode_e'(wr_mode) : mode_q;
    out_mode_d = out_mode_q;
    out_d      = out_q;
    tick_d     = 1'b0;
    if (wr && restart) begin
      count_d    = wr_reload;
      out_mode_d = mode_e'(wr_mode);
      out_d      = 1'b0;
    end else if (en && (count_q == '0)) begin
      // Wrap loads reload_d so a coinciding write takes effect immediately.
      count_d    = reload_d;
      tick_d     = 1'b1;
      out_mode_d = mode_d;
      out_d      = (mode_d == MODE_PULSE) ? 1'b1 : ~out_q;
    end else begin
      if (en) begin
        count_d = count_q - 1'b1;
      end
      if (out_mode_q == MODE_PULSE) begin
        out_d = 1'b0;
      end
    end
  end

  // Channel state register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= DEFAULT_RELOAD;
      reload_q   <= DEFAULT_RELOAD;
      mode_q     <= MODE_TOGGLE;
      out_mode_q <= MODE_TOGGLE;
      out_q      <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      count_q    <= count_d;
      reload_q   <= reload_d;
      mode_q     <= mode_d;
      out_mode_q <= out_mode_d;
      out_q      <= out_d;
      tick_q     <= tick_d;
    end
  end

  assign count   = count_q;
  assign out_pin = out_q;
  assign tick    = tick_q;

endmodule

// File: rtl/prog_divider.sv
// Multi-channel programmable clock divider / LED blinker with counter tap.
module prog_divider
  import prog_divider_pkg::*;
#(
  parameter int unsigned      WIDTH          = DEF_WIDTH,
  parameter int unsigned      CHANNELS       = DEF_CHANNELS,
  parameter logic [WIDTH-1:0] DEFAULT_RELOAD = WIDTH'(DEF_RELOAD),
  parameter int unsigned      TAP_BITS       = DEF_TAP_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] ch_en,
  input  logic                cfg_we,
  input  logic [CH_IDX_W-1:0] cfg_ch,
  input  logic [WIDTH-1:0]    cfg_reload,
  input  logic                cfg_mode,
  input  logic                cfg_restart,
  input  logic [CH_IDX_W-1:0] tap_sel,
  output logic [CHANNELS-1:0] out_pin,
  output logic [CHANNELS-1:0] tick,
  output logic [TAP_BITS-1:0] tap_out
);

  logic [WIDTH-1:0]    count_all [CHANNELS];
  logic [CHANNELS-1:0] wr_sel;

  // Out-of-range cfg_ch matches no channel, so such writes are dropped.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign wr_sel[i] = cfg_we && (cfg_ch == CH_IDX_W'(i));

    prog_divider_ch #(
      .WIDTH          (WIDTH),
      .DEFAULT_RELOAD (DEFAULT_RELOAD)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (ch_en[i]),
      .wr        (wr_sel[i]),
      .restart   (cfg_restart),
      .wr_reload (cfg_reload),
      .wr_mode   (cfg_mode),
      .count     (count_all[i]),
      .out_pin   (out_pin[i]),
      .tick      (tick[i])
    );
  end

  // Tap mux: MSBs of the selected channel's count, zero when out of range.
  always_comb begin
    tap_out = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (tap_sel == CH_IDX_W'(i)) begin
        tap_out = count_all[i][WIDTH-1 -: TAP_BITS];
      end
    end
  end

endmodule

// File: tb/tb_prog_divider.sv
// Self-checking bench for prog_divider (WIDTH=8, CHANNELS=2, reload 3).
module tb_prog_divider;

  localparam int unsigned W  = 8;
  localparam int unsigned NC = 2;
  localparam int unsigned TB = 5;
  localparam logic [W-1:0] DEF = 8'd3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NC-1:0] ch_en;
  logic          cfg_we;
  logic [2:0]    cfg_ch;
  logic [W-1:0]  cfg_reload;
  logic          cfg_mode;
  logic          cfg_restart;
  logic [2:0]    tap_sel;
  logic [NC-1:0] out_pin;
  logic [NC-1:0] tick;
  logic [TB-1:0] tap_out;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: per-channel count, reload, configured mode, mode in
  // force on the output, output level, tick.
  logic [W-1:0] m_cnt [NC];
  logic [W-1:0] m_rld [NC];
  bit           m_mode [NC];
  bit           m_omode [NC];
  bit           m_out [NC];
  bit           m_tick [NC];

  prog_divider #(
    .WIDTH          (W),
    .CHANNELS       (NC),
    .DEFAULT_RELOAD (DEF),
    .TAP_BITS       (TB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ch_en       (ch_en),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_reload  (cfg_reload),
    .cfg_mode    (cfg_mode),
    .cfg_restart (cfg_restart),
    .tap_sel     (tap_sel),
    .out_pin     (out_pin),
    .tick        (tick),
    .tap_out     (tap_out)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_cnt[c] = DEF; m_rld[c] = DEF; m_mode[c] = 1'b0; m_omode[c] = 1'b0;
      m_out[c] = 1'b0; m_tick[c] = 1'b0;
    end
  endtask

  // One clock edge of the behaviour: restart, wrap, decrement or hold.
  task automatic model_edge();
    bit           wr;
    logic [W-1:0] nr;
    bit           nm;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int c = 0; c < NC; c++) begin
      wr = cfg_we && (int'(cfg_ch) == c);
      nr = wr ? cfg_reload : m_rld[c];
      nm = wr ? cfg_mode : m_mode[c];
      m_tick[c] = 1'b0;
      if (wr && cfg_restart) begin
        m_cnt[c] = cfg_reload; m_out[c] = 1'b0; m_omode[c] = cfg_mode;
      end else if (ch_en[c] && m_cnt[c] == 0) begin
        m_cnt[c] = nr; m_tick[c] = 1'b1; m_omode[c] = nm;
        m_out[c] = nm ? 1'b1 : !m_out[c];
      end else begin
        if (ch_en[c]) m_cnt[c] = m_cnt[c] - 8'd1;
        if (m_omode[c]) m_out[c] = 1'b0;
      end
      m_rld[c] = nr;
      m_mode[c] = nm;
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [W-1:0]  sel_cnt;
    logic [TB-1:0] exp_tap;
    for (int c = 0; c < NC; c++) begin
      n_vec++;
      assert (out_pin[c] === m_out[c]) else begin
        n_err++;
        $error("FAIL %s out_pin[%0d] observed %b expected %b", tag, c, out_pin[c], m_out[c]);
      end
      n_vec++;
      assert (tick[c] === m_tick[c]) else begin
        n_err++;
        $error("FAIL %s tick[%0d] observed %b expected %b", tag, c, tick[c], m_tick[c]);
      end
    end
    exp_tap = '0;
    if (tap_sel < 3'(NC)) begin
      sel_cnt = m_cnt[tap_sel];
      exp_tap = sel_cnt[W-1 -: TB];
    end
    n_vec++;
    assert (tap_out === exp_tap) else begin
      n_err++;
      $error("FAIL %s tap_out observed %h expected %h", tag, tap_out, exp_tap);
    end
  endtask

  task automatic do_cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  task automatic cfg_write(input int ch, input logic [W-1:0] rld, input bit md,
                           input bit rs, input string tag);
    cfg_ch = 3'(ch); cfg_reload = rld; cfg_mode = md; cfg_restart = rs; cfg_we = 1'b1;
    do_cycle(tag);
    cfg_we = 1'b0; cfg_restart = 1'b0;
  endtask

  initial begin
    int  ticks;
    int  toggles;
    bit  prev;
    bit  found;

    rst_n = 1'b0; ch_en = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_reload = '0;
    cfg_mode = 1'b0; cfg_restart = 1'b0; tap_sel = '0;
    model_reset();
    #2;
    check_outputs("reset");

    // Both channels run from the default reload.
    @(negedge clk);
    rst_n = 1'b1; ch_en = 2'b11;
    ticks = 0; toggles = 0; prev = out_pin[0];
    for (int k = 0; k < 16; k++) begin
      do_cycle("default_run");
      ticks += int'(tick[0]);
      if (out_pin[0] != prev) toggles++;
      prev = out_pin[0];
    end
    n_vec++;
    assert (ticks == 4) else begin
      n_err++; $error("FAIL default_tick_count observed %0d expected 4", ticks);
    end
    n_vec++;
    assert (toggles == 4) else begin
      n_err++; $error("FAIL default_toggle_count observed %0d expected 4", toggles);
    end

    // Channel 1 to pulse mode, reload 1, restart.
    cfg_write(1, 8'd1, 1'b1, 1'b1, "ch1_pulse_wr");
    for (int k = 0; k < 10; k++) do_cycle("ch1_pulse");

    // Channel 0 reload 7 mid-count without restart.
    do_cycle("pre_mid");
    cfg_write(0, 8'd7, 1'b0, 1'b0, "ch0_mid_wr");
    for (int k = 0; k < 20; k++) do_cycle("ch0_mid");

    // Write landing on a wrap edge is written through.
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (m_cnt[0] == 0) found = 1'b1;
      else do_cycle("seek_wrap");
    end
    n_vec++;
    assert (found) else begin
      n_err++; $error("FAIL seek_wrap timeout observed 0 expected 1");
    end
    cfg_write(0, 8'd7, 1'b0, 1'b0, "ch0_wrap_wr");
    for (int k = 0; k < 18; k++) do_cycle("ch0_wrap");

    // Stop both channels for 5 cycles, then resume.
    do_cycle("pre_stop");
    ch_en = 2'b00;
    for (int k = 0; k < 5; k++) do_cycle("stopped");
    ch_en = 2'b11;
    for (int k = 0; k < 10; k++) do_cycle("resumed");

    // Reload 0 in toggle mode, then an out-of-range write.
    cfg_write(0, 8'd0, 1'b0, 1'b1, "ch0_zero_wr");
    for (int k = 0; k < 6; k++) do_cycle("ch0_zero");
    cfg_write(5, 8'd200, 1'b1, 1'b1, "bad_ch_wr");
    for (int k = 0; k < 6; k++) do_cycle("bad_ch");

    // Asynchronous reset between edges.
    cfg_write(0, 8'd5, 1'b0, 1'b1, "pre_rst_wr");
    for (int k = 0; k < 4; k++) do_cycle("pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(posedge clk);
    #1;
    check_outputs("rst_held");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) do_cycle("post_rst");

    // Randomised traffic.
    for (int k = 0; k < 400; k++) begin
      ch_en = ($urandom_range(0, 7) != 0) ? 2'b11 : NC'($urandom_range(0, 3));
      cfg_we = ($urandom_range(0, 5) == 0);
      cfg_ch = 3'($urandom_range(0, 7) > 5 ? $urandom_range(2, 7) : $urandom_range(0, 1));
      cfg_reload = $urandom_range(0, 1) ? W'($urandom_range(0, 12)) : W'($urandom_range(0, 255));
      cfg_mode = 1'($urandom_range(0, 1));
      cfg_restart = 1'($urandom_range(0, 1));
      tap_sel = 3'($urandom_range(0, 3));
      do_cycle("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
